// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Byte-oriented 8N1 UART transmitter with an internal write FIFO.
// Bytes pushed into the FIFO are serialised as 1 start bit, 8 data bits
// (LSB first) and 1 stop bit, at a programmable bit period.
//
// Parameters
//   FifoDepth    transmit FIFO depth in bytes (power of 2, >= 2)
//   BaudCycBits  width of the bit period configuration
//
// Ports
//   i_clk         sole clock, rising edge
//   i_rst         synchronous active-high reset
//   c_baud_cyc    bit period minus one, in i_clk cycles (quasi-static)
//   i_fifo_write  push i_fifo_wdata into the FIFO (dropped while full)
//   i_fifo_wdata  byte to transmit
//   o_fifo_full   FIFO holds FifoDepth bytes
//   o_fifo_empty  FIFO holds 0 bytes
//   o_busy        a frame is on the line
//   o_tx          serial output, idle high, straight from a flop
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int FifoDepth   = 4,
  parameter int BaudCycBits = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [BaudCycBits-1:0] c_baud_cyc,
  input  logic                   i_fifo_write,
  input  logic [7:0]             i_fifo_wdata,
  output logic                   o_fifo_full,
  output logic                   o_fifo_empty,
  output logic                   o_busy,
  output logic                   o_tx
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  // Transmit FSM state
  state_e                 state_q;
  logic [BaudCycBits-1:0] cyc_cnt_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic                   tx_q;
  logic                   busy_q;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic tick_baud;

  assign fifo_full  = (count_q == CntW'(FifoDepth));
  assign fifo_empty = (count_q == '0);

  // A write while full is dropped even if a pop frees a slot this cycle.
  assign push = i_fifo_write && !fifo_full;

  assign tick_baud = (state_q != IDLE) && (cyc_cnt_q == '0);

  // The FSM takes the head either from IDLE or at the end of a stop bit.
  assign pop = !fifo_empty &&
               ((state_q == IDLE) || ((state_q == STOP_BIT) && tick_baud));

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Power-of-2 depth: the pointers wrap modulo FifoDepth on overflow.
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; a slot is only read after it has
  // been written, and resetting the pointers is enough to flush the FIFO.
  always_ff @(posedge i_clk) begin
    if (push && !i_rst) mem_q[wr_ptr_q] <= i_fifo_wdata;
  end

  // Outputs are registered from the state of the cycle that is ending, so
  // o_tx and o_busy trail the FSM by one cycle and come straight from flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q   <= mem_q[rd_ptr_q];
            cyc_cnt_q <= c_baud_cyc;
            bit_cnt_q <= '0;
            state_q   <= START_BIT;
          end
        end

        START_BIT: begin
          tx_q <= 1'b0;
          if (tick_baud) begin
            cyc_cnt_q <= c_baud_cyc;
            state_q   <= DATA_BITS;
          end else begin
            cyc_cnt_q <= cyc_cnt_q - BaudCycBits'(1);
          end
        end

        DATA_BITS: begin
          tx_q <= shift_q[0];
          if (tick_baud) begin
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            cyc_cnt_q <= c_baud_cyc;
            if (bit_cnt_q == 3'd7) state_q <= STOP_BIT;
          end else begin
            cyc_cnt_q <= cyc_cnt_q - BaudCycBits'(1);
          end
        end

        STOP_BIT: begin
          tx_q <= 1'b1;
          if (tick_baud) begin
            if (pop) begin
              // Next byte waiting: start bit follows with no idle gap.
              shift_q   <= mem_q[rd_ptr_q];
              cyc_cnt_q <= c_baud_cyc;
              bit_cnt_q <= '0;
              state_q   <= START_BIT;
            end else begin
              cyc_cnt_q <= '0;
              state_q   <= IDLE;
            end
          end else begin
            cyc_cnt_q <= cyc_cnt_q - BaudCycBits'(1);
          end
        end
      endcase
    end
  end

  assign o_fifo_full  = fifo_full;
  assign o_fifo_empty = fifo_empty;
  assign o_busy       = busy_q;
  assign o_tx         = tx_q;

endmodule
